// File: rtl/fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_if
//   Instruction-cache request/response port between the fetch controller and
//   the icache.
//   Signals:
//     icache_req_valid   fetch -> icache  request valid
//     icache_addr        fetch -> icache  request address
//     icache_req_ready   icache -> fetch  request accepted this cycle
//     icache_resp_valid  icache -> fetch  instruction returned this cycle
//     icache_resp_data   icache -> fetch  returned instruction word
//   Modports: master (fetch controller side), slave (icache side).
// -----------------------------------------------------------------------------
interface fetch_ctrl_if #(
   parameter int ADDR_BITS = 32,
   parameter int DATA_BITS = 32
);
   logic                 icache_req_valid;
   logic [ADDR_BITS-1:0] icache_addr;
   logic                 icache_req_ready;
   logic                 icache_resp_valid;
   logic [DATA_BITS-1:0] icache_resp_data;

   modport master (
      output icache_req_valid,
      output icache_addr,
      input  icache_req_ready,
      input  icache_resp_valid,
      input  icache_resp_data
   );

   modport slave (
      input  icache_req_valid,
      input  icache_addr,
      output icache_req_ready,
      output icache_resp_valid,
      output icache_resp_data
   );
endinterface

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//   IF-stage fetch sequencer. Owns the fetch PC, keeps at most one request
//   outstanding to the icache, and holds the returned instruction in a
//   single-entry buffer for ID. EX redirects override everything except BOOT;
//   a redirect while a request is in flight marks that request stale so its
//   response is thrown away.
//   Ports:
//     clk             core clock (rising edge)
//     reset           synchronous, active-high
//     stall           ID cannot accept the buffered instruction
//     redirect_valid  EX redirect this cycle
//     redirect_pc     redirect target (low two bits ignored)
//     icache          icache request/response port (master modport)
//     inst_valid      buffer holds a valid instruction
//     inst            buffered instruction word
//     inst_pc         PC of the buffered instruction
// -----------------------------------------------------------------------------
module fetch_ctrl #(
   parameter int                   ADDR_BITS = 32,
   parameter int                   DATA_BITS = 32,
   parameter logic [ADDR_BITS-1:0] RESET_PC  = 32'h0000_1000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 stall,
   input  logic                 redirect_valid,
   input  logic [ADDR_BITS-1:0] redirect_pc,
   fetch_ctrl_if.master         icache,
   output logic                 inst_valid,
   output logic [DATA_BITS-1:0] inst,
   output logic [ADDR_BITS-1:0] inst_pc
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t               state_r,      state_s;
   logic [ADDR_BITS-1:0] pc_r,         pc_s;
   logic                 drop_r,       drop_s;
   logic                 inst_valid_r, inst_valid_s;
   logic [DATA_BITS-1:0] inst_r,       inst_s;
   logic [ADDR_BITS-1:0] inst_pc_r,    inst_pc_s;
   logic                 req_valid_s;
   logic                 consume_s;
   logic [ADDR_BITS-1:0] redirect_tgt_s;

   // Next-state, datapath and request-valid decode
   always_comb begin
      state_s      = state_r;
      pc_s         = pc_r;
      drop_s       = drop_r;
      inst_valid_s = inst_valid_r;
      inst_s       = inst_r;
      inst_pc_s    = inst_pc_r;

      redirect_tgt_s = {redirect_pc[ADDR_BITS-1:2], 2'b00};
      consume_s      = inst_valid_r && !stall;
      // A full, stalled buffer blocks new requests so a response always has room.
      req_valid_s    = (state_r == ST_REQ) && !redirect_valid && (!inst_valid_r || !stall);

      if (consume_s) begin
         inst_valid_s = 1'b0;
      end else begin
         inst_valid_s = inst_valid_r;
      end

      case (state_r)
         ST_BOOT: begin
            state_s = ST_REQ;
         end
         ST_REQ: begin
            if (redirect_valid) begin
               pc_s         = redirect_tgt_s;
               inst_valid_s = 1'b0;
            end else if (req_valid_s && icache.icache_req_ready) begin
               state_s = ST_WAIT;
            end else begin
               state_s = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (icache.icache_resp_valid) begin
               state_s = ST_REQ;
               if (drop_r || redirect_valid) begin
                  // Stale or just-redirected response: discard the word.
                  drop_s = 1'b0;
                  if (redirect_valid) begin
                     pc_s         = redirect_tgt_s;
                     inst_valid_s = 1'b0;
                  end else begin
                     pc_s = pc_r;
                  end
               end else begin
                  inst_s       = icache.icache_resp_data;
                  inst_pc_s    = pc_r;
                  inst_valid_s = 1'b1;
                  pc_s         = pc_r + ADDR_BITS'(3'd4);
               end
            end else if (redirect_valid) begin
               // Request still in flight: remember to drop its response.
               drop_s       = 1'b1;
               pc_s         = redirect_tgt_s;
               inst_valid_s = 1'b0;
            end else begin
               state_s = ST_WAIT;
            end
         end
         default: begin
            state_s = ST_BOOT;
         end
      endcase
   end

   // State and buffer registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_BOOT;
         pc_r         <= RESET_PC;
         drop_r       <= 1'b0;
         inst_valid_r <= 1'b0;
         inst_r       <= '0;
         inst_pc_r    <= '0;
      end else begin
         state_r      <= state_s;
         pc_r         <= pc_s;
         drop_r       <= drop_s;
         inst_valid_r <= inst_valid_s;
         inst_r       <= inst_s;
         inst_pc_r    <= inst_pc_s;
      end
   end

   assign icache.icache_req_valid = req_valid_s;
   assign icache.icache_addr      = pc_r;
   assign inst_valid              = inst_valid_r;
   assign inst                    = inst_r;
   assign inst_pc                 = inst_pc_r;

endmodule
